// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one SOC RAM port between two masters (m0 = CPU, m1 = UART loader /
// debug). Each master strobes a read (rstrb pulse) or a write (nonzero wmask
// pulse). The request is captured into a per-master pending slot. Pending
// slots are granted round-robin, one RAM transaction at a time.
//
// Ports:
//   clk, resetn             system clock, asynchronous active-low reset
//   mX_addr/wdata/wmask     master X request fields, sampled with a strobe
//   mX_rstrb                master X read strobe (one-cycle pulse)
//   mX_rdata                master X read data, held until its next read
//   mX_rbusy / mX_wbusy     master X read / write in progress
//   s_addr/s_wdata          RAM address / write data (registered, held)
//   s_wmask/s_rstrb         RAM write mask / read strobe (one-cycle pulses)
//   s_rdata                 RAM read data, valid MEM_LATENCY edges after the
//                           edge that samples s_rstrb
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wmask,
   input  logic        m0_rstrb,
   output logic [31:0] m0_rdata,
   output logic        m0_rbusy,
   output logic        m0_wbusy,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wmask,
   input  logic        m1_rstrb,
   output logic [31:0] m1_rdata,
   output logic        m1_rbusy,
   output logic        m1_wbusy,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wmask,
   output logic        s_rstrb,
   input  logic [31:0] s_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic [3:0] LATENCY = 4'(MEM_LATENCY);

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             gnt_q, gnt_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [1:0]       pend_rd_q, pend_rd_d;
   logic [1:0]       pend_wr_q, pend_wr_d;
   logic [1:0][31:0] req_addr_q, req_addr_d;
   logic [1:0][31:0] req_wdata_q, req_wdata_d;
   logic [1:0][3:0]  req_wmask_q, req_wmask_d;
   logic [1:0][31:0] rdata_q, rdata_d;
   logic [31:0]      s_addr_q, s_addr_d;
   logic [31:0]      s_wdata_q, s_wdata_d;
   logic [3:0]       s_wmask_q, s_wmask_d;
   logic             s_rstrb_q, s_rstrb_d;

   // Master-indexed views of the two request ports
   logic [1:0][31:0] in_addr;
   logic [1:0][31:0] in_wdata;
   logic [1:0][3:0]  in_wmask;
   logic [1:0]       in_rstrb;
   logic [1:0]       pend_any;

   assign in_addr  = {m1_addr, m0_addr};
   assign in_wdata = {m1_wdata, m0_wdata};
   assign in_wmask = {m1_wmask, m0_wmask};
   assign in_rstrb = {m1_rstrb, m0_rstrb};
   assign pend_any = pend_rd_q | pend_wr_q;

   // Busy includes the strobe cycle itself, before the pending flag is set
   assign m0_rbusy = m0_rstrb | pend_rd_q[0];
   assign m0_wbusy = (m0_wmask != 4'b0000) | pend_wr_q[0];
   assign m1_rbusy = m1_rstrb | pend_rd_q[1];
   assign m1_wbusy = (m1_wmask != 4'b0000) | pend_wr_q[1];

   assign m0_rdata = rdata_q[0];
   assign m1_rdata = rdata_q[1];
   assign s_addr   = s_addr_q;
   assign s_wdata  = s_wdata_q;
   assign s_wmask  = s_wmask_q;
   assign s_rstrb  = s_rstrb_q;

   // Next-state logic: request capture, round-robin grant and RAM sequencing
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      cnt_d        = cnt_q;
      pend_rd_d    = pend_rd_q;
      pend_wr_d    = pend_wr_q;
      req_addr_d   = req_addr_q;
      req_wdata_d  = req_wdata_q;
      req_wmask_d  = req_wmask_q;
      rdata_d      = rdata_q;
      s_addr_d     = s_addr_q;
      s_wdata_d    = s_wdata_q;
      s_wmask_d    = 4'b0000;
      s_rstrb_d    = 1'b0;

      // A strobe is only accepted into an empty slot; a write wins over a
      // simultaneous read strobe.
      for (int m = 0; m < 2; m++) begin
         if (!pend_any[m] && (in_rstrb[m] || (in_wmask[m] != 4'b0000))) begin
            req_addr_d[m]  = in_addr[m];
            req_wdata_d[m] = in_wdata[m];
            req_wmask_d[m] = in_wmask[m];
            if (in_wmask[m] != 4'b0000) begin
               pend_wr_d[m] = 1'b1;
            end else begin
               pend_rd_d[m] = 1'b1;
            end
         end else begin
            // slot busy or no strobe: the captured request stays as it is
            pend_wr_d[m] = pend_wr_d[m];
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (pend_any != 2'b00) begin
               // With both pending, the master not granted last time wins
               if (pend_any == 2'b11) begin
                  gnt_d = ~last_grant_q;
               end else begin
                  gnt_d = pend_any[1];
               end
               last_grant_d = gnt_d;
               s_addr_d     = req_addr_q[gnt_d];
               s_wdata_d    = req_wdata_q[gnt_d];
               if (pend_wr_q[gnt_d]) begin
                  s_wmask_d = req_wmask_q[gnt_d];
               end else begin
                  s_rstrb_d = 1'b1;
               end
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (pend_wr_q[gnt_q]) begin
               pend_wr_d[gnt_q] = 1'b0;
               state_d          = ST_IDLE;
            end else begin
               cnt_d   = LATENCY;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q <= 4'd1) begin
               rdata_d[gnt_q]   = s_rdata;
               pend_rd_d[gnt_q] = 1'b0;
               state_d          = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         gnt_q        <= 1'b0;
         cnt_q        <= 4'd0;
         pend_rd_q    <= 2'b00;
         pend_wr_q    <= 2'b00;
         req_addr_q   <= {2{32'h0000_0000}};
         req_wdata_q  <= {2{32'h0000_0000}};
         req_wmask_q  <= {2{4'b0000}};
         rdata_q      <= {2{32'h0000_0000}};
         s_addr_q     <= 32'h0000_0000;
         s_wdata_q    <= 32'h0000_0000;
         s_wmask_q    <= 4'b0000;
         s_rstrb_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         cnt_q        <= cnt_d;
         pend_rd_q    <= pend_rd_d;
         pend_wr_q    <= pend_wr_d;
         req_addr_q   <= req_addr_d;
         req_wdata_q  <= req_wdata_d;
         req_wmask_q  <= req_wmask_d;
         rdata_q      <= rdata_d;
         s_addr_q     <= s_addr_d;
         s_wdata_q    <= s_wdata_d;
         s_wmask_q    <= s_wmask_d;
         s_rstrb_q    <= s_rstrb_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiter instances: index 0 with MEM_LATENCY=1, index 1 with
// MEM_LATENCY=3, each attached to its own behavioural RAM. Directed scenarios
// check cycle timing; randomized traffic is checked against a word-level
// memory model (each master owns a disjoint 16-word region).
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] m0_addr [2], m0_wdata [2], m1_addr [2], m1_wdata [2];
   logic [3:0]  m0_wmask [2], m1_wmask [2];
   logic        m0_rstrb [2], m1_rstrb [2];
   logic [31:0] m0_rdata [2], m1_rdata [2];
   logic        m0_rbusy [2], m0_wbusy [2], m1_rbusy [2], m1_wbusy [2];
   logic [31:0] s_addr [2], s_wdata [2], s_rdata [2];
   logic [3:0]  s_wmask [2];
   logic        s_rstrb [2];

   logic [31:0] ram     [2][64];
   logic [31:0] pipe    [2][3];
   logic [31:0] ref_mem [2][64];
   logic        ram_fill = 1'b0;

   int passed = 0;
   int total  = 0;
   int lg_model;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_arbiter #(.MEM_LATENCY(g == 0 ? 1 : 3)) u_dut (
         .clk(clk), .resetn(resetn),
         .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]), .m0_wmask(m0_wmask[g]),
         .m0_rstrb(m0_rstrb[g]), .m0_rdata(m0_rdata[g]),
         .m0_rbusy(m0_rbusy[g]), .m0_wbusy(m0_wbusy[g]),
         .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]), .m1_wmask(m1_wmask[g]),
         .m1_rstrb(m1_rstrb[g]), .m1_rdata(m1_rdata[g]),
         .m1_rbusy(m1_rbusy[g]), .m1_wbusy(m1_wbusy[g]),
         .s_addr(s_addr[g]), .s_wdata(s_wdata[g]), .s_wmask(s_wmask[g]),
         .s_rstrb(s_rstrb[g]), .s_rdata(s_rdata[g])
      );
   end

   function automatic logic [31:0] init_word(int g, int i);
      if (g == 0 && i == 16) return 32'hDEAD_BEEF;
      return (32'h1357_0000 * 32'(g + 1)) ^ (32'(i) * 32'h0101_0101) ^ 32'h5A00_00A5;
   endfunction

   // RAM models: byte-masked writes, read data appears LAT edges after s_rstrb is sampled
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (ram_fill) begin
            for (int i = 0; i < 64; i++) ram[g][i] <= init_word(g, i);
         end else begin
            for (int b = 0; b < 4; b++)
               if (s_wmask[g][b]) ram[g][s_addr[g][7:2]][8*b +: 8] <= s_wdata[g][8*b +: 8];
         end
         if (s_rstrb[g]) pipe[g][0] <= ram[g][s_addr[g][7:2]];
         pipe[g][1] <= pipe[g][0];
         pipe[g][2] <= pipe[g][1];
      end
   end

   always_comb begin
      s_rdata[0] = pipe[0][0];
      s_rdata[1] = pipe[1][2];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int g, int m, logic rs, logic [3:0] wm, logic [31:0] a, logic [31:0] wd);
      if (m == 0) begin
         m0_rstrb[g] = rs; m0_wmask[g] = wm; m0_addr[g] = a; m0_wdata[g] = wd;
      end else begin
         m1_rstrb[g] = rs; m1_wmask[g] = wm; m1_addr[g] = a; m1_wdata[g] = wd;
      end
   endtask

   task automatic clear_inputs();
      for (int g = 0; g < 2; g++)
         for (int m = 0; m < 2; m++) drive(g, m, 1'b0, 4'b0000, 32'h0, 32'h0);
   endtask

   function automatic logic get_rbusy(int g, int m);
      return (m == 0) ? m0_rbusy[g] : m1_rbusy[g];
   endfunction

   function automatic logic get_wbusy(int g, int m);
      return (m == 0) ? m0_wbusy[g] : m1_wbusy[g];
   endfunction

   function automatic logic [31:0] get_rdata(int g, int m);
      return (m == 0) ? m0_rdata[g] : m1_rdata[g];
   endfunction

   task automatic do_reset();
      clear_inputs();
      resetn = 1'b0;
      tick(); tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [136:0] v;
      clear_inputs();
      resetn = 1'b0; ram_fill = 1'b1;
      tick();
      ram_fill = 1'b0;
      tick();
      for (int g = 0; g < 2; g++) begin
         v = {m0_rdata[g], m1_rdata[g], s_addr[g], s_wdata[g], s_wmask[g], s_rstrb[g],
              m0_rbusy[g], m0_wbusy[g], m1_rbusy[g], m1_wbusy[g]};
         total++;
         if (v !== 137'd0) $display("FAIL reset_outputs[%0d]: got %h want 0", g, v);
         else passed++;
      end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_read_l1();
      for (int c = 0; c <= 6; c++) begin
         if (c == 0) drive(0, 0, 1'b1, 4'b0000, 32'h40, 32'h0);
         else if (c == 1) drive(0, 0, 1'b0, 4'b0000, 32'h40, 32'h0);
         #1;
         total++;
         if (s_rstrb[0] !== (c == 2)) $display("FAIL rd1_srstrb c%0d: got %b want %b", c, s_rstrb[0], c == 2);
         else passed++;
         if (c == 2) begin
            total++;
            if (s_addr[0] !== 32'h40) $display("FAIL rd1_saddr: got %h want 00000040", s_addr[0]);
            else passed++;
         end
         total++;
         if (m0_rbusy[0] !== (c <= 3)) $display("FAIL rd1_rbusy c%0d: got %b want %b", c, m0_rbusy[0], c <= 3);
         else passed++;
         total++;
         if (m0_rdata[0] !== ((c >= 4) ? 32'hDEAD_BEEF : 32'h0))
            $display("FAIL rd1_rdata c%0d: got %h want %h", c, m0_rdata[0], (c >= 4) ? 32'hDEAD_BEEF : 32'h0);
         else passed++;
         tick();
      end
   endtask

   task automatic test_write();
      logic [31:0] ew;
      for (int c = 0; c <= 4; c++) begin
         if (c == 0) drive(0, 1, 1'b0, 4'b0011, 32'h10, 32'h1234);
         else if (c == 1) drive(0, 1, 1'b0, 4'b0000, 32'h0, 32'h0);
         #1;
         total++;
         if (s_wmask[0] !== ((c == 2) ? 4'b0011 : 4'b0000))
            $display("FAIL wr_smask c%0d: got %b want %b", c, s_wmask[0], (c == 2) ? 4'b0011 : 4'b0000);
         else passed++;
         if (c == 2 || c == 3) begin
            total++;
            if ({s_addr[0], s_wdata[0]} !== {32'h10, 32'h1234})
               $display("FAIL wr_saddr_wdata c%0d: got %h %h want 00000010 00001234", c, s_addr[0], s_wdata[0]);
            else passed++;
         end
         total++;
         if (m1_wbusy[0] !== (c <= 2)) $display("FAIL wr_wbusy c%0d: got %b want %b", c, m1_wbusy[0], c <= 2);
         else passed++;
         tick();
      end
      ew = init_word(0, 4);
      ew[15:0] = 16'h1234;
      total++;
      if (ram[0][4] !== ew) $display("FAIL wr_ram: got %h want %h", ram[0][4], ew);
      else passed++;
   endtask

   task automatic tie_round();
      int w, l;
      w = (lg_model == 1) ? 0 : 1;
      l = 1 - w;
      for (int c = 0; c <= 8; c++) begin
         if (c == 0) begin
            drive(0, 0, 1'b1, 4'b0000, 32'h0, 32'h0);
            drive(0, 1, 1'b1, 4'b0000, 32'h4, 32'h0);
         end else if (c == 1) clear_inputs();
         #1;
         total++;
         if (s_rstrb[0] !== (c == 2 || c == 5)) $display("FAIL tie_srstrb c%0d: got %b", c, s_rstrb[0]);
         else passed++;
         if (c == 2 || c == 5) begin
            total++;
            if (s_addr[0] !== 32'(((c == 2) ? w : l) * 4))
               $display("FAIL tie_order c%0d: got %h want %h", c, s_addr[0], 32'(((c == 2) ? w : l) * 4));
            else passed++;
         end
         total++;
         if (get_rbusy(0, w) !== (c <= 3)) $display("FAIL tie_winner_busy c%0d: got %b want %b", c, get_rbusy(0, w), c <= 3);
         else passed++;
         total++;
         if (get_rbusy(0, l) !== (c <= 6)) $display("FAIL tie_loser_busy c%0d: got %b want %b", c, get_rbusy(0, l), c <= 6);
         else passed++;
         if (c == 8) begin
            total++;
            if ({get_rdata(0, w), get_rdata(0, l)} !== {init_word(0, w), init_word(0, l)})
               $display("FAIL tie_rdata: got %h %h want %h %h", get_rdata(0, w), get_rdata(0, l), init_word(0, w), init_word(0, l));
            else passed++;
         end
         tick();
      end
      lg_model = l;
   endtask

   task automatic test_tie();
      do_reset();
      lg_model = 1;
      tie_round();
      tie_round();
      for (int c = 0; c <= 5; c++) begin
         if (c == 0) drive(0, 0, 1'b1, 4'b0000, 32'h8, 32'h0);
         else if (c == 1) clear_inputs();
         #1;
         if (c == 5) begin
            total++;
            if (m0_rdata[0] !== init_word(0, 2)) $display("FAIL tie_single_rdata: got %h want %h", m0_rdata[0], init_word(0, 2));
            else passed++;
         end
         tick();
      end
      lg_model = 0;
      tie_round();
   endtask

   task automatic test_latency3();
      for (int c = 0; c <= 7; c++) begin
         if (c == 0) drive(1, 0, 1'b1, 4'b0000, 32'h8, 32'h0);
         else if (c == 1) drive(1, 0, 1'b0, 4'b0000, 32'h8, 32'h0);
         #1;
         total++;
         if (s_rstrb[1] !== (c == 2)) $display("FAIL lat3_srstrb c%0d: got %b want %b", c, s_rstrb[1], c == 2);
         else passed++;
         total++;
         if (m0_rbusy[1] !== (c <= 5)) $display("FAIL lat3_rbusy c%0d: got %b want %b", c, m0_rbusy[1], c <= 5);
         else passed++;
         if (c >= 5) begin
            total++;
            if (m0_rdata[1] !== ((c >= 6) ? init_word(1, 2) : 32'h0))
               $display("FAIL lat3_rdata c%0d: got %h want %h", c, m0_rdata[1], (c >= 6) ? init_word(1, 2) : 32'h0);
            else passed++;
         end
         tick();
      end
   endtask

   task automatic test_rw_together();
      logic [31:0] ew;
      for (int c = 0; c <= 6; c++) begin
         if (c == 0) drive(1, 0, 1'b1, 4'b1100, 32'h30, 32'hCAFE_F00D);
         else if (c == 1) drive(1, 0, 1'b0, 4'b0000, 32'h30, 32'h0);
         #1;
         total++;
         if (s_rstrb[1] !== 1'b0) $display("FAIL rw_no_srstrb c%0d: got %b want 0", c, s_rstrb[1]);
         else passed++;
         total++;
         if (s_wmask[1] !== ((c == 2) ? 4'b1100 : 4'b0000))
            $display("FAIL rw_smask c%0d: got %b want %b", c, s_wmask[1], (c == 2) ? 4'b1100 : 4'b0000);
         else passed++;
         total++;
         if ({m0_wbusy[1], m0_rbusy[1]} !== {c <= 2, c == 0})
            $display("FAIL rw_busy c%0d: got %b%b want %b%b", c, m0_wbusy[1], m0_rbusy[1], c <= 2, c == 0);
         else passed++;
         tick();
      end
      ew = init_word(1, 12);
      ew[31:16] = 16'hCAFE;
      total++;
      if (ram[1][12] !== ew) $display("FAIL rw_ram: got %h want %h", ram[1][12], ew);
      else passed++;
   endtask

   task automatic test_ignored_strobe();
      int n;
      n = 0;
      for (int c = 0; c <= 7; c++) begin
         if (c == 0) drive(0, 0, 1'b1, 4'b0000, 32'h20, 32'h0);
         else if (c == 1) drive(0, 0, 1'b1, 4'b0000, 32'h24, 32'h0);
         else if (c == 2) drive(0, 0, 1'b0, 4'b0000, 32'h24, 32'h0);
         #1;
         if (s_rstrb[0]) begin
            n++;
            total++;
            if (s_addr[0] !== 32'h20) $display("FAIL ign_saddr: got %h want 00000020", s_addr[0]);
            else passed++;
         end
         tick();
      end
      total++;
      if (n != 1) $display("FAIL ign_count: got %0d strobes want 1", n);
      else passed++;
      total++;
      if (m0_rdata[0] !== init_word(0, 8)) $display("FAIL ign_rdata: got %h want %h", m0_rdata[0], init_word(0, 8));
      else passed++;
   endtask

   task automatic test_reset_mid_read();
      logic [136:0] v;
      for (int c = 0; c <= 10; c++) begin
         if (c == 0) drive(1, 0, 1'b1, 4'b0000, 32'h14, 32'h0);
         else if (c == 1) drive(1, 0, 1'b0, 4'b0000, 32'h14, 32'h0);
         if (c == 4) resetn = 1'b0;
         if (c == 6) resetn = 1'b1;
         #1;
         if (c == 2) begin
            total++;
            if ({s_rstrb[1], s_addr[1]} !== {1'b1, 32'h14}) $display("FAIL rmr_issue: got %b %h want 1 00000014", s_rstrb[1], s_addr[1]);
            else passed++;
         end
         if (c == 4) begin
            v = {m0_rdata[1], m1_rdata[1], s_addr[1], s_wdata[1], s_wmask[1], s_rstrb[1],
                 m0_rbusy[1], m0_wbusy[1], m1_rbusy[1], m1_wbusy[1]};
            total++;
            if (v !== 137'd0) $display("FAIL rmr_outputs: got %h want 0", v);
            else passed++;
         end
         if (c >= 4) begin
            total++;
            if (s_rstrb[1] !== 1'b0) $display("FAIL rmr_no_strobe c%0d: got %b want 0", c, s_rstrb[1]);
            else passed++;
         end
         if (c == 10) begin
            total++;
            if (m0_rdata[1] !== 32'h0) $display("FAIL rmr_abandoned: got %h want 0", m0_rdata[1]);
            else passed++;
         end
         tick();
      end
      for (int c = 0; c <= 7; c++) begin
         if (c == 0) drive(1, 0, 1'b1, 4'b0000, 32'h18, 32'h0);
         else if (c == 1) drive(1, 0, 1'b0, 4'b0000, 32'h18, 32'h0);
         #1;
         if (c == 5 || c == 6) begin
            total++;
            if (m0_rbusy[1] !== (c == 5)) $display("FAIL rmr_new_busy c%0d: got %b want %b", c, m0_rbusy[1], c == 5);
            else passed++;
         end
         if (c == 6) begin
            total++;
            if (m0_rdata[1] !== init_word(1, 6)) $display("FAIL rmr_new_rdata: got %h want %h", m0_rdata[1], init_word(1, 6));
            else passed++;
         end
         tick();
      end
   endtask

   task automatic test_random(int g, int nops);
      logic        outst [2];
      logic        is_rd [2];
      logic [31:0] expv  [2];
      int          age   [2];
      int          issued [2];
      int          cyc, word;
      bit          abort;
      logic [3:0]  wm;
      logic [31:0] wd, nv;
      ram_fill = 1'b1;
      tick();
      ram_fill = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[g][i] = init_word(g, i);
      for (int m = 0; m < 2; m++) begin
         outst[m] = 1'b0; is_rd[m] = 1'b0; expv[m] = 32'h0; age[m] = 0; issued[m] = 0;
      end
      cyc = 0; abort = 1'b0;
      while (!abort && cyc < 3000 && (issued[0] < nops || issued[1] < nops || outst[0] || outst[1])) begin
         for (int m = 0; m < 2; m++) drive(g, m, 1'b0, 4'b0000, 32'h0, 32'h0);
         #1;
         for (int m = 0; m < 2; m++) begin
            if (outst[m]) begin
               if (!get_rbusy(g, m) && !get_wbusy(g, m)) begin
                  if (is_rd[m]) begin
                     total++;
                     if (get_rdata(g, m) !== expv[m])
                        $display("FAIL rnd_rdata[%0d] m%0d: got %h want %h", g, m, get_rdata(g, m), expv[m]);
                     else passed++;
                  end
                  outst[m] = 1'b0;
               end else begin
                  age[m]++;
                  if (age[m] > 40) begin
                     total++;
                     $display("FAIL rnd_timeout[%0d] m%0d: busy for %0d cycles, want completion", g, m, age[m]);
                     abort = 1'b1;
                  end
               end
            end
         end
         for (int m = 0; m < 2; m++) begin
            if (!outst[m] && issued[m] < nops && $urandom_range(0, 2) == 0) begin
               word = m * 16 + int'($urandom_range(0, 15));
               if ($urandom_range(0, 1) == 0) begin
                  is_rd[m] = 1'b1;
                  expv[m]  = ref_mem[g][word];
                  drive(g, m, 1'b1, 4'b0000, 32'(word * 4), 32'h0);
               end else begin
                  wm = 4'($urandom_range(1, 15));
                  wd = $urandom;
                  nv = ref_mem[g][word];
                  for (int b = 0; b < 4; b++) if (wm[b]) nv[8*b +: 8] = wd[8*b +: 8];
                  ref_mem[g][word] = nv;
                  is_rd[m] = 1'b0;
                  drive(g, m, 1'b0, wm, 32'(word * 4), wd);
               end
               outst[m] = 1'b1; age[m] = 0; issued[m]++;
            end
         end
         #1;
         tick();
         cyc++;
      end
      clear_inputs();
      total++;
      if (abort || cyc >= 3000) $display("FAIL rnd_complete[%0d]: got %0d cycles abort=%0b want all ops done", g, cyc, abort);
      else passed++;
      for (int i = 0; i < 32; i++) begin
         total++;
         if (ram[g][i] !== ref_mem[g][i]) $display("FAIL rnd_ram[%0d][%0d]: got %h want %h", g, i, ram[g][i], ref_mem[g][i]);
         else passed++;
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_read_l1();
      test_write();
      test_tie();
      test_latency3();
      test_rw_together();
      test_ignored_strobe();
      test_reset_mid_read();
      test_random(0, 40);
      test_random(1, 40);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
